// File: rtl/can_tx_pkg.sv
// CAN transmit-side shared types and constants.
// Header field values and serialiser FSM states.
package can_tx_pkg;

  localparam int HEADER_LEN = 19;
  localparam int STUFF_RUN  = 5;

  localparam logic SOF_BIT = 1'b0;
  localparam logic IDE_BIT = 1'b0;
  localparam logic R0_BIT  = 1'b0;

  typedef enum logic [2:0] {
    s_idle,
    s_arm,
    s_header,
    s_stuff,
    s_finish
  } hdrTx_t;

  // Bit 0 goes on the wire first (SOF), bit 18 last (DLC[0]).
  function automatic logic [18:0] hdr_build(
    input logic [10:0] id,
    input logic        rtr,
    input logic [3:0]  dlc
  );
    logic [18:0] h;
    h     = '0;
    h[0]  = SOF_BIT;
    for (int i = 0; i < 11; i++) begin
      h[1+i] = id[10-i];
    end
    h[12] = rtr;
    h[13] = IDE_BIT;
    h[14] = R0_BIT;
    for (int i = 0; i < 4; i++) begin
      h[15+i] = dlc[3-i];
    end
    return h;
  endfunction

endpackage

// File: rtl/can_stuff_tracker.sv
// Identical-bit run tracker for CAN bit stuffing.
// Shared by the header and data/CRC serialisers.
module can_stuff_tracker #(
  parameter int STUFF_RUN = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       bitVld_i,
  input  logic       bitVal_i,
  input  logic       restart_i,
  output logic [2:0] runCount_o,
  output logic       lastBit_o,
  output logic       stuffNeeded_o
);

  localparam logic [2:0] RUN3 = 3'(STUFF_RUN);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       last_q;
  logic       last_d;

  // Next run length: a restart or a level change opens a new run.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (bitVld_i) begin
      if (restart_i || (bitVal_i != last_q)) begin
        cnt_d = 3'd1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      last_d = bitVal_i;
    end
  end

  // Run state registers; idle line is recessive.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q  <= 3'd0;
      last_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign runCount_o    = cnt_q;
  assign lastBit_o     = last_q;
  assign stuffNeeded_o = (cnt_q == RUN3);

endmodule

// File: rtl/can_header_stuffer.sv
// CAN 2.0A header serialiser with on-the-fly stuffing.
// Emits SOF..DLC one bit per bitTick and hands off run state.
module can_header_stuffer #(
  parameter int HEADER_LEN = can_tx_pkg::HEADER_LEN,
  parameter int STUFF_RUN  = can_tx_pkg::STUFF_RUN
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [10:0] canId,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic        bitTick,
  output logic        dOut,
  output logic        busy,
  output logic        stuffActive,
  output logic        done,
  output logic [2:0]  runCount,
  output logic        lastBit
);

  import can_tx_pkg::*;

  localparam logic [4:0] LEN5 = 5'(HEADER_LEN);

  hdrTx_t      state_q;
  hdrTx_t      state_d;
  logic [18:0] hdr_q;
  logic [18:0] hdr_d;
  logic [4:0]  idx_q;
  logic [4:0]  idx_d;
  logic        dout_q;
  logic        dout_d;
  logic        stuff_q;
  logic        stuff_d;
  logic        busy_q;
  logic        busy_d;
  logic        done_q;
  logic        done_d;

  logic        trkVld;
  logic        trkBit;
  logic        trkRst;
  logic        stuffNeeded;
  logic        trkLast;

  can_stuff_tracker #(
    .STUFF_RUN(STUFF_RUN)
  ) u_trk (
    .clk          (clk),
    .resetN       (resetN),
    .bitVld_i     (trkVld),
    .bitVal_i     (trkBit),
    .restart_i    (trkRst),
    .runCount_o   (runCount),
    .lastBit_o    (trkLast),
    .stuffNeeded_o(stuffNeeded)
  );

  // Sequencing: stuff bits win over header bits and never
  // advance the index; the tick after the last bit finishes.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    stuff_d = stuff_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    trkVld  = 1'b0;
    trkBit  = 1'b0;
    trkRst  = 1'b0;
    unique case (state_q)
      s_idle: begin
        if (start) begin
          hdr_d   = hdr_build(canId, rtr, dlc);
          idx_d   = 5'd0;
          busy_d  = 1'b1;
          state_d = s_arm;
        end
      end
      s_arm: begin
        if (bitTick) begin
          trkVld  = 1'b1;
          trkRst  = 1'b1;
          trkBit  = hdr_q[0];
          dout_d  = hdr_q[0];
          stuff_d = 1'b0;
          idx_d   = 5'd1;
          state_d = s_header;
        end
      end
      s_header, s_stuff: begin
        if (bitTick) begin
          if (stuffNeeded) begin
            trkVld  = 1'b1;
            trkBit  = ~trkLast;
            dout_d  = ~trkLast;
            stuff_d = 1'b1;
            state_d = s_stuff;
          end else if (idx_q < LEN5) begin
            trkVld  = 1'b1;
            trkBit  = hdr_q[idx_q];
            dout_d  = hdr_q[idx_q];
            stuff_d = 1'b0;
            idx_d   = idx_q + 5'd1;
            state_d = s_header;
          end else begin
            dout_d  = 1'b1;
            stuff_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = s_finish;
          end
        end
      end
      s_finish: begin
        state_d = s_idle;
      end
      default: begin
        state_d = s_idle;
      end
    endcase
  end

  // Frame state and registered line outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= s_idle;
      hdr_q   <= '0;
      idx_q   <= 5'd0;
      dout_q  <= 1'b1;
      stuff_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      stuff_q <= stuff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dOut        = dout_q;
  assign busy        = busy_q;
  assign stuffActive = stuff_q;
  assign done        = done_q;
  assign lastBit     = trkLast;

endmodule
